// File: rtl/gpu_pkg.sv
// Shared encodings for the GPU core: core FSM states, writeback source
// selects and the register-file layout (13 GPRs plus 3 read-only specials).
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  // Writeback source select; 2'b11 is reserved and never writes.
  localparam logic [1:0] MUX_ARITH = 2'b00;
  localparam logic [1:0] MUX_MEM   = 2'b01;
  localparam logic [1:0] MUX_CONST = 2'b10;

  localparam logic [3:0] REG_BLOCK_ID  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM = 4'd14;
  localparam logic [3:0] REG_THREAD_ID = 4'd15;

  localparam int NUM_GPRS = 13;

endpackage

// File: rtl/thread_regfile.sv
// Per-thread register file: registered rs/rt operand reads in REQUEST,
// writeback of ALU/LSU/immediate results and NZP flag capture in UPDATE.
// r13..r15 are read-only specials (block id, block dim, thread id).
module thread_regfile #(
  parameter int DATA_BITS         = 16,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [7:0]           decoded_immediate,
  input  logic                 decoded_nzp_write_enable,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt,
  output logic [2:0]           nzp
);

  import gpu_pkg::*;

  logic [DATA_BITS-1:0] regs [NUM_GPRS];

  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_fire;
  logic                 nzp_fire;
  logic                 in_request;

  // Shared operand read mux; block_id is taken live so it is never stale.
  function automatic logic [DATA_BITS-1:0] read_reg(input logic [3:0] addr);
    logic [DATA_BITS-1:0] val;
    case (addr)
      REG_BLOCK_ID:  val = DATA_BITS'(block_id);
      REG_BLOCK_DIM: val = DATA_BITS'(THREADS_PER_BLOCK);
      REG_THREAD_ID: val = DATA_BITS'(THREAD_ID);
      default:       val = regs[addr];
    endcase
    return val;
  endfunction

  // Select the writeback value; the reserved mux code suppresses the write.
  always_comb begin
    wr_data  = '0;
    wr_valid = 1'b0;
    case (decoded_reg_input_mux)
      MUX_ARITH: begin
        wr_data  = alu_out;
        wr_valid = 1'b1;
      end
      MUX_MEM: begin
        wr_data  = lsu_out;
        wr_valid = 1'b1;
      end
      MUX_CONST: begin
        wr_data  = DATA_BITS'(decoded_immediate);
        wr_valid = 1'b1;
      end
      default: begin
        wr_data  = '0;
        wr_valid = 1'b0;
      end
    endcase
  end

  // Qualify reads and writes by core state; writes to r13..r15 are dropped.
  always_comb begin
    in_request = enable && (core_state == CORE_REQUEST);
    if (enable && (core_state == CORE_UPDATE)) begin
      wr_fire  = decoded_reg_write_enable && wr_valid &&
                 (decoded_rd_address < 4'(NUM_GPRS));
      nzp_fire = decoded_nzp_write_enable;
    end else begin
      wr_fire  = 1'b0;
      nzp_fire = 1'b0;
    end
  end

  // Register state: synchronous reset wins over everything, else hold unless fired.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPRS; i++) begin
        regs[i] <= '0;
      end
      rs  <= '0;
      rt  <= '0;
      nzp <= 3'b000;
    end else begin
      if (in_request) begin
        rs <= read_reg(decoded_rs_address);
        rt <= read_reg(decoded_rt_address);
      end
      if (wr_fire) begin
        regs[decoded_rd_address] <= wr_data;
      end
      if (nzp_fire) begin
        nzp <= alu_out[2:0];
      end
    end
  end

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile: stimulus pushes hand-computed expected
// rs/rt/nzp values into a queue; a negedge monitor pops and compares them.
module tb_thread_regfile;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  block_id;
  logic [2:0]  core_state;
  logic [3:0]  rd_a, rs_a, rt_a;
  logic        reg_we;
  logic [1:0]  in_mux;
  logic [7:0]  imm;
  logic        nzp_we;
  logic [15:0] alu_out, lsu_out;
  logic [15:0] rs, rt;
  logic [2:0]  nzp;

  typedef struct {
    int          tag;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [2:0]  nzp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;

  thread_regfile #(.DATA_BITS(16), .THREADS_PER_BLOCK(4), .THREAD_ID(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
    .core_state(core_state),
    .decoded_rd_address(rd_a), .decoded_rs_address(rs_a),
    .decoded_rt_address(rt_a), .decoded_reg_write_enable(reg_we),
    .decoded_reg_input_mux(in_mux), .decoded_immediate(imm),
    .decoded_nzp_write_enable(nzp_we),
    .alu_out(alu_out), .lsu_out(lsu_out),
    .rs(rs), .rt(rt), .nzp(nzp)
  );

  always #5 clk = ~clk;

  // Monitor: compare every pending expectation against the settled outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 3;
      if (rs !== e.rs) begin
        errors++;
        $display("FAIL rs chk%0d: got %h expected %h", e.tag, rs, e.rs);
      end
      if (rt !== e.rt) begin
        errors++;
        $display("FAIL rt chk%0d: got %h expected %h", e.tag, rt, e.rt);
      end
      if (nzp !== e.nzp) begin
        errors++;
        $display("FAIL nzp chk%0d: got %b expected %b", e.tag, nzp, e.nzp);
      end
    end
  end

  task automatic tick(input logic [2:0] s);
    core_state = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [15:0] ers, input logic [15:0] ert,
                            input logic [2:0] enzp);
    exp_t e;
    tag++;
    e.tag = tag; e.rs = ers; e.rt = ert; e.nzp = enzp;
    exp_q.push_back(e);
  endtask

  // FETCH..EXECUTE of one instruction; operands checked after REQUEST.
  task automatic do_req(input logic [3:0] a, input logic [3:0] b,
                        input logic [15:0] ers, input logic [15:0] ert,
                        input logic [2:0] enzp);
    rs_a = a; rt_a = b;
    tick(CORE_FETCH);
    tick(CORE_DECODE);
    tick(CORE_REQUEST);
    expect_out(ers, ert, enzp);
    tick(CORE_WAIT);
    tick(CORE_EXECUTE);
  endtask

  // One UPDATE cycle; rs/rt must hold, nzp checked after the edge.
  task automatic do_upd(input logic [3:0] rd, input logic we, input logic [1:0] mux,
                        input logic [7:0] im, input logic [15:0] alu,
                        input logic [15:0] lsu, input logic nwe,
                        input logic [15:0] ers, input logic [15:0] ert,
                        input logic [2:0] enzp);
    rd_a = rd; reg_we = we; in_mux = mux; imm = im;
    alu_out = alu; lsu_out = lsu; nzp_we = nwe;
    tick(CORE_UPDATE);
    expect_out(ers, ert, enzp);
    reg_we = 1'b0; nzp_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; block_id = 8'd7; core_state = CORE_IDLE;
    rd_a = 4'd0; rs_a = 4'd0; rt_a = 4'd0; reg_we = 1'b0; in_mux = 2'b00;
    imm = 8'h00; nzp_we = 1'b0; alu_out = 16'h0000; lsu_out = 16'h0000;
    tick(CORE_IDLE);
    tick(CORE_IDLE);
    reset = 1'b0;
    expect_out(16'h0000, 16'h0000, 3'b000);

    do_req(4'd3, 4'd15, 16'h0000, 16'h0002, 3'b000);
    do_upd(4'd5, 1'b1, MUX_CONST, 8'hA7, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0002, 3'b000);
    do_req(4'd5, 4'd14, 16'h00A7, 16'h0004, 3'b000);
    do_upd(4'd4, 1'b1, MUX_ARITH, 8'h00, 16'h1234, 16'h0000, 1'b0, 16'h00A7, 16'h0004, 3'b000);
    do_upd(4'd6, 1'b1, MUX_MEM, 8'h00, 16'h0000, 16'hBEEF, 1'b0, 16'h00A7, 16'h0004, 3'b000);
    do_req(4'd4, 4'd6, 16'h1234, 16'hBEEF, 3'b000);
    // Write to r13 dropped; reserved mux leaves r5 alone.
    do_upd(4'd13, 1'b1, MUX_ARITH, 8'h00, 16'hFFFF, 16'h0000, 1'b0, 16'h1234, 16'hBEEF, 3'b000);
    do_upd(4'd5, 1'b1, 2'b11, 8'h77, 16'h5555, 16'h6666, 1'b0, 16'h1234, 16'hBEEF, 3'b000);
    do_req(4'd13, 4'd5, 16'h0007, 16'h00A7, 3'b000);
    do_upd(4'd0, 1'b0, MUX_ARITH, 8'h00, 16'h0004, 16'h0000, 1'b1, 16'h0007, 16'h00A7, 3'b100);

    // Thread disabled: nothing may change.
    enable = 1'b0;
    do_upd(4'd4, 1'b1, MUX_CONST, 8'h11, 16'h0001, 16'h0000, 1'b1, 16'h0007, 16'h00A7, 3'b100);
    do_req(4'd4, 4'd6, 16'h0007, 16'h00A7, 3'b100);
    enable = 1'b1;
    do_req(4'd4, 4'd0, 16'h1234, 16'h0000, 3'b100);

    // Register and NZP write in the same UPDATE; r12 is the last writable.
    do_upd(4'd2, 1'b1, MUX_CONST, 8'h09, 16'h0001, 16'h0000, 1'b1, 16'h1234, 16'h0000, 3'b001);
    do_upd(4'd12, 1'b1, MUX_CONST, 8'hFF, 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'h0000, 3'b001);
    do_req(4'd2, 4'd12, 16'h0009, 16'h00FF, 3'b001);
    block_id = 8'h3C;
    do_req(4'd13, 4'd15, 16'h003C, 16'h0002, 3'b001);

    // Reset asserted in EXECUTE clears everything on that edge.
    rs_a = 4'd2; rt_a = 4'd5;
    tick(CORE_FETCH);
    tick(CORE_DECODE);
    tick(CORE_REQUEST);
    expect_out(16'h0009, 16'h00A7, 3'b001);
    tick(CORE_WAIT);
    reset = 1'b1;
    tick(CORE_EXECUTE);
    reset = 1'b0;
    expect_out(16'h0000, 16'h0000, 3'b000);
    do_upd(4'd3, 1'b1, MUX_CONST, 8'h55, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'b000);
    do_req(4'd2, 4'd12, 16'h0000, 16'h0000, 3'b000);
    do_req(4'd3, 4'd5, 16'h0055, 16'h0000, 3'b000);

    tick(CORE_DONE);
    tick(CORE_IDLE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/thread_regfile.md
# thread_regfile

Per-thread register file that feeds `rs`/`rt` operands to the thread's ALU and accepts the ALU result back for writeback. It also captures the ALU compare flags into the thread's NZP register. There is one instance per thread per core, sequenced by the core's `core_state`. It holds 13 general-purpose registers plus 3 read-only special registers: block ID, block dimension and thread ID.

## Interface
Parameters:
- `DATA_BITS`, 16: register and datapath width.
- `THREADS_PER_BLOCK`, 4: constant returned by r14.
- `THREAD_ID`, 0: constant returned by r15 (this thread's index).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: thread active; when low, all state holds.
- `block_id`, in, 8: current block index, exposed as r13.
- `core_state`, in, 3: core FSM state.
- `decoded_rd_address`, in, 4: destination register.
- `decoded_rs_address`, in, 4: source register for `rs`.
- `decoded_rt_address`, in, 4: source register for `rt`.
- `decoded_reg_write_enable`, in, 1: write rd in UPDATE.
- `decoded_reg_input_mux`, in, 2: writeback source select.
- `decoded_immediate`, in, 8: constant for CONST.
- `decoded_nzp_write_enable`, in, 1: capture NZP in UPDATE.
- `alu_out`, in, `DATA_BITS`: ALU result; bits [2:0] = {P, Z, N} on compare.
- `lsu_out`, in, `DATA_BITS`: load data.
- `rs`, out, `DATA_BITS`: registered operand A.
- `rt`, out, `DATA_BITS`: registered operand B.
- `nzp`, out, 3: {P, Z, N} flags for the branch unit.

## Operation
- Core states: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- Read, at a REQUEST posedge with `enable` high:
  - `rs <= R[decoded_rs_address]`.
  - `rt <= R[decoded_rt_address]`.
- Special-register reads:
  - Reads of r13 return `{'0, block_id}`, taken directly from the input (bypass, no staleness).
  - Reads of r14 return `THREADS_PER_BLOCK`, truncated/zero-extended to `DATA_BITS`.
  - Reads of r15 return `THREAD_ID`, truncated/zero-extended to `DATA_BITS`.
- Write, at an UPDATE posedge with `enable` and `decoded_reg_write_enable` high, and `decoded_rd_address` ≤ 12. The value written is selected by `decoded_reg_input_mux`:
  - 00 ARITH: `alu_out`.
  - 01 MEM: `lsu_out`.
  - 10 CONST: `decoded_immediate`, zero-extended.
  - 11 reserved: no write.
- Writes to r13–r15 are silently dropped.
- NZP: at an UPDATE posedge with `enable` and `decoded_nzp_write_enable` high, `nzp <= alu_out[2:0]`.
- A register write and an NZP write in the same UPDATE cycle are legal and independent.
- In all other states, or with `enable` low, registers, `rs`, `rt` and `nzp` hold.
- Arithmetic: none is performed in this block; all data passes through unmodified apart from zero-extension.

## Timing
- Reset (synchronous, highest priority, overrides `enable` and any in-progress state):
  - r0–r12 = 0.
  - `rs` = 0, `rt` = 0, `nzp` = 3'b000.
- Operand latency: `rs`/`rt` are valid from the cycle after the REQUEST posedge, and stable through WAIT and EXECUTE.
- Writeback latency: the new register value is visible to a REQUEST of the next instruction. Reads and writes never coincide because REQUEST and UPDATE are distinct states, so no bypass is needed.
- `nzp` updates on the UPDATE edge and is valid for the following FETCH/branch decision.
- Reset asserted mid-instruction, e.g. in EXECUTE, clears all state on that edge. The following UPDATE, if any, writes normally.

## Structure
- Shared package `gpu_pkg`:
  - core-state encodings;
  - reg-input-mux encodings (ARITH, MEM, CONST);
  - special-register indices `REG_BLOCK_ID` = 13, `REG_BLOCK_DIM` = 14, `REG_THREAD_ID` = 15;
  - `NUM_GPRS` = 13.
- No sub-module; a single flat module with one read-mux function shared by `rs` and `rt`.

## Test plan
- Reset, then REQUEST with rs=3, rt=15, `THREAD_ID`=2 -> `rs`=0, `rt`=2, `nzp`=000.
- UPDATE with rd=5, mux=CONST, imm=8'hA7, we=1; next REQUEST with rs=5 -> `rs`=16'h00A7.
- UPDATE with rd=4, mux=ARITH, `alu_out`=16'h1234; UPDATE with rd=6, mux=MEM, `lsu_out`=16'hBEEF -> reads of r4 and r6 return 1234 and BEEF.
- UPDATE with rd=13, we=1, `alu_out`=16'hFFFF, `block_id`=7 -> a later read of r13 returns 7. UPDATE with mux=11 -> no register changes.
- UPDATE with nzp_we=1, `alu_out`=16'h0004 -> `nzp`=100. Same test with `enable`=0 -> `nzp` unchanged.
- Write r2=9, then assert reset during EXECUTE -> r2 reads 0, and `rs`/`rt`/`nzp` are 0 on the next cycle.
